// File: rtl/wb_pic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pic_pkg
//  Description : Shared constants and state encoding for the wb_pic block.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pic_pkg;

    localparam logic [1:0] PIC_IMR   = 2'd0;
    localparam logic [1:0] PIC_IRR   = 2'd1;
    localparam logic [1:0] PIC_ISR   = 2'd2;
    localparam logic [1:0] PIC_VBASE = 2'd3;

    // EOI command word layout on a write to the ISR register
    localparam int EOI_NS_BIT  = 4;
    localparam int EOI_IDX_LSB = 0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } pic_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_pic_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pic_if
//  Description : Wishbone slave bus bundle for the interrupt controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_pic_if;
    logic [1:0]  wb_adr_i;
    logic [1:0]  wb_sel_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_sel_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_sel_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_pic_prio.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pic_prio
//  Description : Combinational priority encoder, lowest set index wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_pic_prio #(
    parameter int NUM_IRQ = 16,
    parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  wire logic [NUM_IRQ-1:0] i_req,
    output logic                    o_valid,
    output logic [IDX_W-1:0]        o_idx
);

    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        // Scan downward so the last hit, the lowest index, is kept
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = i[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_pic.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pic
//  Description : Wishbone-programmable 16-line priority interrupt controller
//                with nesting, feeding one vector at a time to the CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_pic
    import wb_pic_pkg::*;
#(
    parameter int          NUM_IRQ      = 16,
    parameter logic [7:0]  VEC_BASE_RST = 8'h08,
    parameter logic [15:0] IMR_RST      = 16'hFFFF
) (
    input  wire logic               wb_clk_i,
    input  wire logic               wb_rst_i,
    wb_pic_if.slave                 wb,
    input  wire logic [NUM_IRQ-1:0] irq_i,
    output logic                    interrupt_do_o,
    output logic [7:0]              interrupt_vector_o,
    input  wire logic               interrupt_done_i
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    pic_state_t         r_state;
    pic_state_t         w_state_next;
    logic               w_latch;

    logic [NUM_IRQ-1:0] r_irq_q;
    logic [NUM_IRQ-1:0] r_irr;
    logic [NUM_IRQ-1:0] r_isr;
    logic [NUM_IRQ-1:0] r_imr;
    logic [7:0]         r_vbase;
    logic [IDX_W-1:0]   r_idx;
    logic [7:0]         r_vec;
    logic               r_ack;
    logic [15:0]        r_dat;

    logic               w_acc;
    logic               w_wr;
    logic [15:0]        w_wmask;
    logic [15:0]        w_dat_m;
    logic [15:0]        w_imr16;
    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_clr_wb;
    logic [NUM_IRQ-1:0] w_clr_ack;
    logic [NUM_IRQ-1:0] w_limit;
    logic [NUM_IRQ-1:0] w_elig;
    logic               w_elig_valid;
    logic [IDX_W-1:0]   w_elig_idx;
    logic               w_isr_valid;
    logic [IDX_W-1:0]   w_isr_idx;
    logic               w_eoi;
    logic [IDX_W-1:0]   w_eoi_idx;
    logic [NUM_IRQ-1:0] w_eoi_clr;
    logic [15:0]        w_rd_dat;

    // Bus decode: one access per stb/cyc, committed on the cycle the ack is registered
    assign w_acc   = wb.wb_stb_i & wb.wb_cyc_i & ~r_ack;
    assign w_wr    = w_acc & wb.wb_we_i;
    assign w_wmask = {{8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
    assign w_dat_m = wb.wb_dat_i & w_wmask;
    assign w_imr16 = (16'(r_imr) & ~w_wmask) | w_dat_m;

    assign w_edge    = irq_i & ~r_irq_q;
    assign w_clr_wb  = (w_wr && (wb.wb_adr_i == PIC_IRR)) ? w_dat_m[NUM_IRQ-1:0] : '0;
    assign w_clr_ack = ((r_state == ST_REQ) && interrupt_done_i) ? (NUM_IRQ'(1) << r_idx) : '0;

    // Only lines strictly above the highest in-service level may interrupt
    assign w_limit = w_isr_valid ? ((NUM_IRQ'(1) << w_isr_idx) - NUM_IRQ'(1)) : '1;
    assign w_elig  = r_irr & ~r_imr & w_limit;

    assign w_eoi     = w_wr && (wb.wb_adr_i == PIC_ISR) && wb.wb_sel_i[0];
    assign w_eoi_idx = wb.wb_dat_i[EOI_NS_BIT] ? w_isr_idx : wb.wb_dat_i[EOI_IDX_LSB +: IDX_W];
    assign w_eoi_clr = (w_eoi && (!wb.wb_dat_i[EOI_NS_BIT] || w_isr_valid))
                     ? (NUM_IRQ'(1) << w_eoi_idx) : '0;

    wb_pic_prio #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_prio_elig (
        .i_req   (w_elig),
        .o_valid (w_elig_valid),
        .o_idx   (w_elig_idx)
    );

    wb_pic_prio #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_prio_isr (
        .i_req   (r_isr),
        .o_valid (w_isr_valid),
        .o_idx   (w_isr_idx)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_latch        = 1'b0;
        interrupt_do_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_elig_valid) begin
                    w_latch      = 1'b1;
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                interrupt_do_o = 1'b1;
                if (interrupt_done_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rd_dat = '0;
        case (wb.wb_adr_i)
            PIC_IMR:   w_rd_dat = 16'(r_imr);
            PIC_IRR:   w_rd_dat = 16'(r_irr);
            PIC_ISR:   w_rd_dat = 16'(r_isr);
            PIC_VBASE: w_rd_dat = {8'h00, r_vbase};
            default:   w_rd_dat = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_irq_q <= '0;
            r_irr   <= '0;
            r_isr   <= '0;
            r_imr   <= IMR_RST[NUM_IRQ-1:0];
            r_vbase <= VEC_BASE_RST;
            r_idx   <= '0;
            r_vec   <= '0;
            r_ack   <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_irq_q <= irq_i;
            // A fresh edge outranks any clear landing in the same cycle
            r_irr   <= (r_irr & ~w_clr_ack & ~w_clr_wb) | w_edge;
            r_isr   <= (r_isr & ~w_eoi_clr) | w_clr_ack;
            r_ack   <= w_acc;
            if (w_acc) begin
                r_dat <= w_rd_dat;
            end
            if (w_wr && (wb.wb_adr_i == PIC_IMR)) begin
                r_imr <= w_imr16[NUM_IRQ-1:0];
            end
            if (w_wr && (wb.wb_adr_i == PIC_VBASE) && wb.wb_sel_i[0]) begin
                r_vbase <= wb.wb_dat_i[7:0];
            end
            if (w_latch) begin
                r_idx <= w_elig_idx;
                r_vec <= r_vbase + 8'(w_elig_idx);
            end
        end
    end

    assign wb.wb_ack_o        = r_ack;
    assign wb.wb_dat_o        = r_dat;
    assign interrupt_vector_o = r_vec;

endmodule
`default_nettype wire

// File: doc/wb_pic.md
# wb_pic

Wishbone-configurable 16-input priority interrupt controller that arbitrates the board's `hardware_irq[15:0]` lines (UART on IRQ4) and delivers one vector at a time to the ao486 over its `interrupt_do` / `interrupt_vector` / `interrupt_done` handshake. It sits on the Wishbone I/O bus next to `serial` and `post`. It runs on `wb_clk` and `wb_rst`. Software programs the mask, the vector base and end-of-interrupt through four 16-bit registers.

## Interface
- `NUM_IRQ`, 16, number of request lines; fixed priority, index 0 highest.
- `VEC_BASE_RST`, 8'h08, reset value of the vector base register.
- `IMR_RST`, 16'hFFFF, reset value of the mask register (all masked).

Ports:
- `wb_clk_i`  in  1  system clock; the only clock.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `wb_adr_i`  in  2  register select (bus address [2:1]).
- `wb_sel_i`  in  2  byte lane enables.
- `wb_dat_i`  in  16  write data.
- `wb_dat_o`  out  16  read data.
- `wb_we_i`, `wb_stb_i`, `wb_cyc_i`  in  1  Wishbone control.
- `wb_ack_o`  out  1  single-cycle acknowledge.
- `irq_i`  in  NUM_IRQ  request lines, synchronous to `wb_clk_i`, rising-edge triggered.
- `interrupt_do_o`  out  1  vector-pending request to the CPU.
- `interrupt_vector_o`  out  8  vector; stable while `interrupt_do_o` is high.
- `interrupt_done_i`  in  1  one-cycle CPU acceptance pulse.

## Operation
Registers (selected by `wb_adr_i`):
- 0 IMR: read/write mask; 1 = masked.
- 1 IRR: read pending. A write clears the IRR bits where data is 1 (W1C).
- 2 ISR: read in-service. A write with `sel[0]` performs EOI:
  - `dat[4]`=1: non-specific EOI; clears the highest-priority set ISR bit.
  - `dat[4]`=0: specific EOI; clears ISR bit `dat[3:0]`.
- 3 VBASE: bits [7:0] are the vector base; bits [15:8] read as 0 and ignore writes.
- Byte lanes: writes honour `wb_sel_i` for regs 0, 1 and 3.

Request detection and update:
- Edge detection uses a registered `irq_q`. An edge is `irq_i & ~irq_q`.
- IRR update: `IRR_next = (IRR & ~clr_ack & ~clr_wb) | edge`. A new edge wins over any clear in the same cycle.
- Eligible set: `IRR & ~IMR`, further limited to indices strictly higher in priority (lower index) than the highest set ISR bit. This gives nested interrupts.

State machine:
- IDLE: if any line is eligible, latch the winning index `k` and the vector `VBASE + k` (8-bit, wraps modulo 256), then go to REQ.
- REQ: `interrupt_do_o`=1 with the vector held. The latched choice is not preempted or withdrawn by later edges, masking, or W1C of IRR. When `interrupt_done_i`=1: clear `IRR[k]`, set `ISR[k]`, go to IDLE.
- `interrupt_done_i` seen in IDLE is ignored.

Wishbone:
- `wb_ack_o` is registered: `stb & cyc & ~ack`, so one ack per access. Back-to-back accesses take 2 cycles each.
- Read data is registered together with the ack.

Reset:
- Any cycle with `wb_rst_i`=1, including mid-REQ, returns the block to IDLE.
- Reset values: `interrupt_do_o`=0, `interrupt_vector_o`=0, `wb_ack_o`=0, `wb_dat_o`=0, IRR=0, ISR=0, `irq_q`=0, IMR=`IMR_RST`, VBASE=`VEC_BASE_RST`.

## Timing
- Edge on `irq_i` sampled at cycle N: IRR bit set at N+1, `interrupt_do_o` high at N+2.
- `interrupt_done_i` at cycle M: `interrupt_do_o` low and ISR set at M+1. The next `interrupt_do_o` is high at M+2 at the earliest.
- Register writes take effect on the ack cycle. An IMR or EOI write at cycle W affects IDLE selection from W+1.
- Wishbone ack is asserted exactly 1 cycle after `stb & cyc` rises.

## Structure
- Package `wb_pic_pkg` holds:
  - register address constants (`PIC_IMR`=0, `PIC_IRR`=1, `PIC_ISR`=2, `PIC_VBASE`=3);
  - the state encoding (IDLE, REQ);
  - the EOI field positions.
- Sub-module `wb_pic_prio`: combinational NUM_IRQ→{valid, index} lowest-index priority encoder. It is instantiated twice: once for the eligible set, once for the highest ISR bit (used by the nesting limit and non-specific EOI).

## Test plan
- Reset, then read all registers: IMR=FFFF, IRR=0, ISR=0, VBASE=0008. Pulse `irq_i[4]` → IRR=0010, and `interrupt_do_o` stays 0 because IRQ4 is masked.
- Write IMR=FFEF, pulse `irq_i[4]` at N → `interrupt_do_o` at N+2, vector 8'h0C. `interrupt_done_i` → ISR=0010, IRR=0.
- With IRQ4 in service, pulse IRQ6 then IRQ1 (IMR=0) → IRQ6 is held pending and IRQ1 is delivered with vector 09. After non-specific EOI twice, ISR=0; IRQ6 is delivered only after IRQ4 is cleared.
- Edge on `irq_i[3]` in the same cycle as `interrupt_done_i` for IRQ3 → ISR[3]=1 and IRR[3]=1, and a re-request follows EOI.
- VBASE=FE, IRQ3 unmasked → vector 8'h01 (wrap).
- Assert `wb_rst_i` during REQ → `interrupt_do_o`=0 the next cycle and all registers at reset values. A later `interrupt_done_i` is ignored.
